// File: rtl/lanectrl_pause_pkg.sv
// Shared types and limits for the multi-lane HS_IO_CLK_PAUSE conditioner.
// Holds the per-lane state encoding, the lane counter width and the
// legal parameter ranges checked at elaboration by the top level.
package lanectrl_pause_pkg;

  // Per-lane pause conditioning states
  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_ASSERT = 2'd1,
    LANE_HOLD   = 2'd2,
    LANE_GAP    = 2'd3
  } lane_state_e;

  // Width of the per-lane pulse/gap down-counter
  localparam int LANE_CNT_W = 4;

  // Legal parameter ranges
  localparam int NUM_LANES_MIN   = 1;
  localparam int NUM_LANES_MAX   = 16;
  localparam int SYNC_STAGES_MIN = 1;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int MIN_PULSE_MIN   = 1;
  localparam int MIN_PULSE_MAX   = 15;
  localparam int MIN_GAP_MIN     = 0;
  localparam int MIN_GAP_MAX     = 15;
  localparam int CNT_W_MIN       = 1;

endpackage

// File: rtl/lanectrl_pause_lane.sv
// One pause lane: synchroniser chain, width-enforcing FSM and its counter.
// out_o is registered; stretch_evt_o is a one-cycle strobe issued on the
// cycle a stretched pulse finishes its minimum-width phase.
module lanectrl_pause_lane
  import lanectrl_pause_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter int MIN_GAP     = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pause_i,
  input  logic mask_i,
  output logic out_o,
  output logic stretch_evt_o
);

  localparam logic [LANE_CNT_W-1:0] PULSE_LOAD = LANE_CNT_W'(MIN_PULSE - 1);
  localparam logic [LANE_CNT_W-1:0] GAP_LOAD   =
      LANE_CNT_W'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);
  localparam bit HAS_GAP = (MIN_GAP > 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  lane_state_e            state_q, state_d;
  logic [LANE_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   fell_q, fell_d;   // s dropped during ASSERT
  logic                   pend_q, pend_d;   // request seen during GAP
  logic                   out_q, out_d;
  logic                   stretch_evt;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First synchroniser stage captures the asynchronous request
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) sync_q[0] <= 1'b0;
          else       sync_q[0] <= pause_i;
        end
      end else begin : g_next
        // Further stages settle metastability
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) sync_q[gi] <= 1'b0;
          else       sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign s = sync_q[SYNC_STAGES-1];

  // State, counter, flags and output register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= LANE_IDLE;
      cnt_q   <= '0;
      fell_q  <= 1'b0;
      pend_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fell_q  <= fell_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic; a cleared mask overrides everything and drops to IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fell_d      = fell_q;
    pend_d      = pend_q;
    stretch_evt = 1'b0;
    case (state_q)
      LANE_IDLE: begin
        if ((s || pend_q) && mask_i) begin
          state_d = LANE_ASSERT;
          cnt_d   = PULSE_LOAD;
          fell_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      LANE_ASSERT: begin
        if (!s) fell_d = 1'b0 | 1'b1;
        if (cnt_q == '0) begin
          stretch_evt = fell_q || !s;
          if (s) begin
            state_d = LANE_HOLD;
          end else if (HAS_GAP) begin
            state_d = LANE_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = LANE_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LANE_HOLD: begin
        if (!s) begin
          if (HAS_GAP) begin
            state_d = LANE_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = LANE_IDLE;
          end
        end
      end
      LANE_GAP: begin
        // A short request arriving here is remembered and served from IDLE
        if (s) pend_d = 1'b1;
        if (cnt_q == '0) state_d = LANE_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = LANE_IDLE;
    endcase
    if (!mask_i) begin
      state_d     = LANE_IDLE;
      pend_d      = 1'b0;
      stretch_evt = 1'b0;
    end
    out_d = (state_d == LANE_ASSERT) || (state_d == LANE_HOLD);
  end

  assign out_o         = out_q;
  assign stretch_evt_o = stretch_evt;

endmodule

// File: rtl/lanectrl_pause_sync_multi.sv
// Multi-lane HS_IO_CLK_PAUSE synchroniser/conditioner with aggregate status
// and a saturating count of stretched pulses.
// Optional build macro LANECTRL_PAUSE_NEGEDGE_OUT_EN re-registers the lane
// outputs on the falling edge of CLK for negedge-sampling clock gates.
module lanectrl_pause_sync_multi
  import lanectrl_pause_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter int MIN_GAP     = 1,
  parameter int CNT_W       = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  input  logic [NUM_LANES-1:0] LANE_MASK,
  input  logic                 CNT_CLR,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
  output logic                 PAUSE_ANY,
  output logic                 PAUSE_ALL,
  output logic [CNT_W-1:0]     STRETCH_CNT
);

  // Extra headroom so up to 16 simultaneous events never wrap before saturation
  localparam int EXT_W = CNT_W + 5;
  localparam logic [EXT_W-1:0] SAT_VAL = EXT_W'({CNT_W{1'b1}});

  generate
    if (NUM_LANES < NUM_LANES_MIN || NUM_LANES > NUM_LANES_MAX) begin : g_bad_lanes
      $error("lanectrl_pause_sync_multi: NUM_LANES out of range");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("lanectrl_pause_sync_multi: SYNC_STAGES out of range");
    end
    if (MIN_PULSE < MIN_PULSE_MIN || MIN_PULSE > MIN_PULSE_MAX) begin : g_bad_pulse
      $error("lanectrl_pause_sync_multi: MIN_PULSE out of range");
    end
    if (MIN_GAP < MIN_GAP_MIN || MIN_GAP > MIN_GAP_MAX) begin : g_bad_gap
      $error("lanectrl_pause_sync_multi: MIN_GAP out of range");
    end
    if (CNT_W < CNT_W_MIN) begin : g_bad_cnt
      $error("lanectrl_pause_sync_multi: CNT_W out of range");
    end
  endgenerate

  logic [NUM_LANES-1:0] lane_out;
  logic [NUM_LANES-1:0] lane_evt;
  logic [NUM_LANES-1:0] pause_vec;
  logic [EXT_W-1:0]     evt_sum;
  logic [EXT_W-1:0]     sum_ext;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lanectrl_pause_lane #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_PULSE   (MIN_PULSE),
        .MIN_GAP     (MIN_GAP)
      ) u_lane (
        .CLK           (CLK),
        .RESET         (RESET),
        .pause_i       (HS_IO_CLK_PAUSE[gi]),
        .mask_i        (LANE_MASK[gi]),
        .out_o         (lane_out[gi]),
        .stretch_evt_o (lane_evt[gi])
      );
    end
  endgenerate

`ifdef LANECTRL_PAUSE_NEGEDGE_OUT_EN
  logic [NUM_LANES-1:0] out_neg_q;

  // Half-cycle retime of the lane outputs for opposite-edge consumers
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) out_neg_q <= '0;
    else       out_neg_q <= lane_out;
  end

  assign pause_vec = out_neg_q;
`else
  assign pause_vec = lane_out;
`endif

  assign HS_IO_CLK_PAUSE_SYNC = pause_vec;
  assign PAUSE_ANY = |pause_vec;
  // Masked lanes count as paused; an all-masked block reports not paused
  assign PAUSE_ALL = (|LANE_MASK) & (&(pause_vec | ~LANE_MASK));

  // Population count of lanes finishing a stretched pulse this cycle
  always_comb begin
    evt_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      evt_sum = evt_sum + EXT_W'(lane_evt[i]);
    end
  end

  // Saturating increment; clear wins over any same-cycle increment
  always_comb begin
    sum_ext = EXT_W'(cnt_q) + evt_sum;
    if (CNT_CLR)               cnt_d = '0;
    else if (sum_ext > SAT_VAL) cnt_d = {CNT_W{1'b1}};
    else                       cnt_d = sum_ext[CNT_W-1:0];
  end

  // Stretch counter register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign STRETCH_CNT = cnt_q;

endmodule
